clk_gate_ctrl: RTL and testbench

Idle-detect clock-gating controller for one gated clock domain. It runs on the free-running clock and drives the enable input of the domain's glitch-free latch-based clock gate. It gates the domain after a programmable idle hysteresis, and restores the clock on a wake request with a fixed settle window before acknowledging. It sits beside the domain's clk_gate instance; software/PMU provides global enable and force-on controls.

---
 rtl/clk_gate_ctrl_if.sv | 25 ++
 rtl/clk_gate_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_if.sv
// rtl/clk_gate_ctrl_if.sv - control/status bundle between PMU side and clk_gate_ctrl
interface clk_gate_ctrl_if #(
    parameter int STAT_W = 32
);
    logic              ctrl_enable;
    logic              force_on;
    logic              dom_busy;
    logic              wake_req;
    logic              stat_clr;
    logic              clk_en;
    logic              gated;
    logic              wake_ack;
    logic [1:0]        state;
    logic [STAT_W-1:0] stat_gated_cycles;

    modport master (
        output ctrl_enable, force_on, dom_busy, wake_req, stat_clr,
        input  clk_en, gated, wake_ack, state, stat_gated_cycles
    );

    modport slave (
        input  ctrl_enable, force_on, dom_busy, wake_req, stat_clr,
        output clk_en, gated, wake_ack, state, stat_gated_cycles
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - idle-detect clock-gate enable controller with wake settle window
// Optional gated-cycle statistics counter enabled by CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int STAT_W      = 32
) (
    input  logic           clk_in,
    input  logic           rst_in,
    clk_gate_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_IDLE_CNT = 2'b01,
        ST_GATED    = 2'b10,
        ST_WAKE     = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_en_q;
    logic             gated_q;
    logic             wake_ack_q;
    logic             idle;
    logic             wake_src;

    assign idle     = bus.ctrl_enable & ~bus.force_on & ~bus.dom_busy & ~bus.wake_req;
    assign wake_src = bus.wake_req | bus.force_on | ~bus.ctrl_enable;

    // Outputs are registered alongside the state so clk_en never sees input glitches.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            clk_en_q   <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
        end else begin
            wake_ack_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (idle) begin
                        state_q <= ST_IDLE_CNT;
                        cnt_q   <= '0;
                    end
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                end
                ST_IDLE_CNT: begin
                    if (!idle) begin
                        state_q  <= ST_RUN;
                        cnt_q    <= '0;
                        clk_en_q <= 1'b1;
                        gated_q  <= 1'b0;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_q  <= ST_GATED;
                        clk_en_q <= 1'b0;
                        gated_q  <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        clk_en_q <= 1'b1;
                        gated_q  <= 1'b0;
                    end
                end
                ST_GATED: begin
                    if (wake_src) begin
                        state_q  <= ST_WAKE;
                        cnt_q    <= '0;
                        clk_en_q <= 1'b1;
                        gated_q  <= 1'b0;
                    end else begin
                        clk_en_q <= 1'b0;
                        gated_q  <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // A wake always completes its settle window before acking.
                    if (cnt_q == WAKE_LAST) begin
                        state_q    <= ST_RUN;
                        cnt_q      <= '0;
                        wake_ack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_RUN;
                    cnt_q    <= '0;
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_en   = clk_en_q;
    assign bus.gated    = gated_q;
    assign bus.wake_ack = wake_ack_q;
    assign bus.state    = state_q;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stat_q <= '0;
        end else if (bus.stat_clr) begin
            stat_q <= '0;
        end else if (state_q == ST_GATED && stat_q != {STAT_W{1'b1}}) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign bus.stat_gated_cycles = stat_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr       = bus.stat_clr;
    assign bus.stat_gated_cycles = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

    localparam int STAT_W = 4;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    clk_gate_ctrl_if #(.STAT_W(STAT_W)) bus ();

    clk_gate_ctrl #(
        .IDLE_CYCLES(16),
        .WAKE_CYCLES(2),
        .CNT_W      (8),
        .STAT_W     (STAT_W)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic en,
                           input logic gt, input logic ack);
        chk({tag, ".state"}, 32'(bus.state), 32'(st));
        chk({tag, ".clk_en"}, 32'(bus.clk_en), 32'(en));
        chk({tag, ".gated"}, 32'(bus.gated), 32'(gt));
        chk({tag, ".wake_ack"}, 32'(bus.wake_ack), 32'(ack));
    endtask

    initial begin
        bus.ctrl_enable = 1'b1;
        bus.force_on    = 1'b0;
        bus.dom_busy    = 1'b0;
        bus.wake_req    = 1'b0;
        bus.stat_clr    = 1'b0;
        #12;
        chk_out("reset", 2'b00, 1'b1, 1'b0, 1'b0);
        chk("reset.stat", 32'(bus.stat_gated_cycles), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Idle from reset release: gates after edge 16
        step(1);
        chk_out("idle_e0", 2'b01, 1'b1, 1'b0, 1'b0);
        step(15);
        chk_out("idle_e15", 2'b01, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("idle_e16", 2'b10, 1'b0, 1'b1, 1'b0);

        // Wake via wake_req, held past the ack
        bus.wake_req = 1'b1;
        step(1);
        chk_out("wake_w0", 2'b11, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("wake_w1", 2'b11, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("wake_w2", 2'b00, 1'b1, 1'b0, 1'b1);
        step(1);
        chk_out("wake_hold", 2'b00, 1'b1, 1'b0, 1'b0);
        bus.wake_req = 1'b0;

        // Busy pulse at cnt=10 aborts the idle count
        step(1);
        chk_out("busy_e0", 2'b01, 1'b1, 1'b0, 1'b0);
        step(10);
        bus.dom_busy = 1'b1;
        step(1);
        chk_out("busy_abort", 2'b00, 1'b1, 1'b0, 1'b0);
        bus.dom_busy = 1'b0;
        step(1);
        chk_out("busy_restart", 2'b01, 1'b1, 1'b0, 1'b0);
        step(15);
        chk_out("busy_e15", 2'b01, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("busy_gated", 2'b10, 1'b0, 1'b1, 1'b0);

        // busy is ignored while gated
        bus.dom_busy = 1'b1;
        step(3);
        chk_out("gated_busy", 2'b10, 1'b0, 1'b1, 1'b0);
        bus.dom_busy = 1'b0;

        // Dropping ctrl_enable while gated wakes with an ack
        bus.ctrl_enable = 1'b0;
        step(1);
        chk_out("dis_w0", 2'b11, 1'b1, 1'b0, 1'b0);
        step(2);
        chk_out("dis_w2", 2'b00, 1'b1, 1'b0, 1'b1);
        step(20);
        chk_out("dis_hold", 2'b00, 1'b1, 1'b0, 1'b0);

        bus.ctrl_enable = 1'b1;
        bus.force_on    = 1'b1;
        step(20);
        chk_out("force_hold", 2'b00, 1'b1, 1'b0, 1'b0);
        bus.force_on = 1'b0;
        step(17);
        chk_out("regate", 2'b10, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges while gated
        #2;
        rst_in = 1'b1;
        #1;
        chk_out("async_rst", 2'b00, 1'b1, 1'b0, 1'b0);
        chk("async_rst.stat", 32'(bus.stat_gated_cycles), 32'd0);
        rst_in = 1'b0;
        step(1);
        chk_out("post_rst", 2'b01, 1'b1, 1'b0, 1'b0);

        // Statistics: gated at E16, then 20 more gated edges
        step(16);
        chk_out("stat_gate", 2'b10, 1'b0, 1'b1, 1'b0);
        step(20);
`ifdef CLK_GATE_CTRL_STATS_EN
        chk("stat_sat", 32'(bus.stat_gated_cycles), 32'd15);
        bus.stat_clr = 1'b1;
        step(1);
        chk("stat_clr", 32'(bus.stat_gated_cycles), 32'd0);
        bus.stat_clr = 1'b0;
        step(1);
        chk("stat_resume", 32'(bus.stat_gated_cycles), 32'd1);
`else
        chk("stat_tied", 32'(bus.stat_gated_cycles), 32'd0);
        bus.stat_clr = 1'b1;
        step(1);
        chk("stat_tied_clr", 32'(bus.stat_gated_cycles), 32'd0);
        bus.stat_clr = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
